// File: rtl/exec_ctrl_pkg.sv
// Shared types and encodings for the RV32I execute sequencer and its ALU interface.
package exec_ctrl_pkg;

    // Opcode presented to the integer ALU.
    typedef enum logic [3:0] {
        ALU_ADD      = 4'd0,
        ALU_SUB      = 4'd1,
        ALU_SLL      = 4'd2,
        ALU_SLT      = 4'd3,
        ALU_SLTU     = 4'd4,
        ALU_XOR      = 4'd5,
        ALU_SRL      = 4'd6,
        ALU_SRA      = 4'd7,
        ALU_OR       = 4'd8,
        ALU_AND      = 4'd9,
        ALU_PASS_RS2 = 4'd10
    } alu_op_t;

    // Major opcodes handled by the sequencer.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Branch funct3 encodings.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Index of each flag inside the ALU branch status word {eq, lt, ltu}.
    localparam int BSR_EQ  = 2;
    localparam int BSR_LT  = 1;
    localparam int BSR_LTU = 0;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        TGT  = 2'd2,
        DONE = 2'd3
    } exec_state_t;

    // Map an OP/OP-IMM funct3 to the ALU opcode; alt selects SUB/SRA.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch decision from funct3 and the ALU status of rs1 - rs2.
    function automatic logic branch_taken(input logic [2:0] f3, input logic [2:0] bsr);
        logic taken;
        case (f3)
            F3_BEQ:  taken =  bsr[BSR_EQ];
            F3_BNE:  taken = !bsr[BSR_EQ];
            F3_BLT:  taken =  bsr[BSR_LT];
            F3_BGE:  taken = !bsr[BSR_LT];
            F3_BLTU: taken =  bsr[BSR_LTU];
            F3_BGEU: taken = !bsr[BSR_LTU];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exec_ctrl_imm_gen.sv
// Immediate extraction for the I/B/J/U formats, sign-extended to WIDTH.
// Takes only bits [31:7]; the opcode field carries no immediate bits.
module exec_ctrl_imm_gen #(
    parameter int WIDTH = 32
) (
    input  logic [31:7]      instr,
    output logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] imm_b,
    output logic [WIDTH-1:0] imm_j,
    output logic [WIDTH-1:0] imm_u
);

    // Reassemble each format's scattered immediate bits, then sign-extend.
    always_comb begin
        imm_i = WIDTH'($signed(instr[31:20]));
        imm_b = WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        imm_j = WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        imm_u = WIDTH'($signed({instr[31:12], 12'b0}));
    end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle RV32I execute sequencer: takes one instruction, drives the
// external ALU for one or two cycles and returns writeback / redirect info.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output alu_op_t          alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [2:0]       alu_bsr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_rd,
    output logic             res_wb_en,
    output logic [WIDTH-1:0] res_data,
    output logic             res_redirect,
    output logic [WIDTH-1:0] res_target,
    output logic             res_illegal,
    output logic             res_misaligned
);

    exec_state_t      state_q, state_d;

    // Latched instruction context.
    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] rs1_q, rs1_d;
    logic [WIDTH-1:0] rs2_q, rs2_d;

    // Result being assembled in EXEC/TGT and presented in DONE.
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             wb_en_q, wb_en_d;
    logic             redirect_q, redirect_d;
    logic             illegal_q, illegal_d;
    logic             misaligned_q, misaligned_d;

    // Instruction fields.
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd_field;

    logic [WIDTH-1:0] imm_i, imm_b, imm_j, imm_u;

    // EXEC-cycle decode results.
    alu_op_t          ex_op;
    logic [WIDTH-1:0] ex_a, ex_b;
    logic             ex_writes;
    logic             ex_illegal;
    logic             ex_is_branch;
    logic             ex_is_jump;

    // TGT-cycle operands and masked target.
    logic             is_jalr;
    logic [WIDTH-1:0] tgt_a, tgt_b;
    logic [WIDTH-1:0] tgt_addr;

    logic             res_on;

    assign opcode   = instr_q[6:0];
    assign rd_field = instr_q[11:7];
    assign funct3   = instr_q[14:12];
    assign funct7   = instr_q[31:25];

    exec_ctrl_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr (instr_q[31:7]),
        .imm_i (imm_i),
        .imm_b (imm_b),
        .imm_j (imm_j),
        .imm_u (imm_u)
    );

    // Decode the latched instruction into ALU operands for the EXEC cycle.
    always_comb begin
        ex_op        = ALU_ADD;
        ex_a         = '0;
        ex_b         = '0;
        ex_writes    = 1'b0;
        ex_illegal   = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jump   = 1'b0;
        case (opcode)
            OPC_OP: begin
                ex_a      = rs1_q;
                ex_b      = rs2_q;
                ex_writes = 1'b1;
                if (funct7 == 7'b0000000) begin
                    ex_op = f3_to_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    ex_op = f3_to_op(funct3, 1'b1);
                end else begin
                    ex_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                ex_a      = rs1_q;
                ex_b      = imm_i;
                ex_writes = 1'b1;
                // Only the shifts constrain the upper immediate bits.
                if (funct3 == 3'b001) begin
                    ex_op = ALU_SLL;
                    if (funct7 != 7'b0000000) ex_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000) begin
                        ex_op = ALU_SRL;
                    end else if (funct7 == 7'b0100000) begin
                        ex_op = ALU_SRA;
                    end else begin
                        ex_illegal = 1'b1;
                    end
                end else begin
                    ex_op = f3_to_op(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                ex_op     = ALU_PASS_RS2;
                ex_b      = imm_u;
                ex_writes = 1'b1;
            end
            OPC_AUIPC: begin
                ex_a      = pc_q;
                ex_b      = imm_u;
                ex_writes = 1'b1;
            end
            OPC_JAL: begin
                ex_a       = pc_q;
                ex_b       = WIDTH'(4);
                ex_writes  = 1'b1;
                ex_is_jump = 1'b1;
            end
            OPC_JALR: begin
                ex_a       = pc_q;
                ex_b       = WIDTH'(4);
                ex_writes  = 1'b1;
                ex_is_jump = 1'b1;
                if (funct3 != 3'b000) ex_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                ex_op        = ALU_SUB;
                ex_a         = rs1_q;
                ex_b         = rs2_q;
                ex_is_branch = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) ex_illegal = 1'b1;
            end
            default: begin
                ex_illegal = 1'b1;
            end
        endcase
    end

    // Select target-address operands; JALR targets drop bit 0.
    always_comb begin
        is_jalr  = (opcode == OPC_JALR);
        tgt_a    = is_jalr ? rs1_q : pc_q;
        if (opcode == OPC_JAL) begin
            tgt_b = imm_j;
        end else if (opcode == OPC_BRANCH) begin
            tgt_b = imm_b;
        end else begin
            tgt_b = imm_i;
        end
        tgt_addr = alu_y & {{(WIDTH-1){1'b1}}, ~is_jalr};
    end

    // Next-state, ALU drive and result assembly.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        data_d       = data_q;
        target_d     = target_q;
        wb_en_d      = wb_en_q;
        redirect_d   = redirect_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        alu_op       = ALU_ADD;
        alu_a        = '0;
        alu_b        = '0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    instr_d = in_instr;
                    pc_d    = in_pc;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_op       = ex_op;
                alu_a        = ex_a;
                alu_b        = ex_b;
                illegal_d    = ex_illegal;
                misaligned_d = 1'b0;
                redirect_d   = 1'b0;
                target_d     = '0;
                rd_d         = (ex_writes && !ex_illegal) ? rd_field : 5'd0;
                data_d       = (ex_writes && !ex_illegal) ? alu_y : '0;
                wb_en_d      = ex_writes && !ex_illegal && (rd_field != 5'd0);
                if (!ex_illegal &&
                    (ex_is_jump || (ex_is_branch && branch_taken(funct3, alu_bsr)))) begin
                    state_d = TGT;
                end else begin
                    state_d = DONE;
                end
            end
            TGT: begin
                alu_op   = ALU_ADD;
                alu_a    = tgt_a;
                alu_b    = tgt_b;
                target_d = tgt_addr;
                if (tgt_addr[1:0] != 2'b00) begin
                    misaligned_d = 1'b1;
                    redirect_d   = 1'b0;
                    wb_en_d      = 1'b0;
                end else begin
                    redirect_d   = 1'b1;
                end
                state_d = DONE;
            end
            default: begin
                if (res_ready) state_d = IDLE;
            end
        endcase
    end

    // Control state: reset returns to IDLE and clears result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wb_en_q      <= 1'b0;
            redirect_q   <= 1'b0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_en_q      <= wb_en_d;
            redirect_q   <= redirect_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Datapath registers; their outputs are masked outside DONE.
    always_ff @(posedge clk) begin
        instr_q  <= instr_d;
        pc_q     <= pc_d;
        rs1_q    <= rs1_d;
        rs2_q    <= rs2_d;
        rd_q     <= rd_d;
        data_q   <= data_d;
        target_q <= target_d;
    end

    // Result port is live only in DONE and forced quiet during reset.
    assign res_on         = (state_q == DONE) && !rst;
    assign in_ready       = (state_q == IDLE) && !rst;
    assign res_valid      = res_on;
    assign res_rd         = res_on ? rd_q : 5'd0;
    assign res_wb_en      = res_on && wb_en_q;
    assign res_data       = res_on ? data_q : '0;
    assign res_redirect   = res_on && redirect_q;
    assign res_target     = res_on ? target_q : '0;
    assign res_illegal    = res_on && illegal_q;
    assign res_misaligned = res_on && misaligned_q;

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Multi-cycle execute sequencer for the RV32I core. Accepts one decoded-register instruction via valid/ready, drives the integer ALU's operand/opcode inputs over 1–2 cycles, consumes ALU result and branch status (bsr), and returns writeback data plus a PC redirect via a second valid/ready handshake.
- It is the driving/consuming end of the ALU interface: it produces alu_op_t and interprets bsr.

Parameters:
- WIDTH, 32, datapath width (RV32I only; other values unsupported)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept
- in_instr  in  32  raw instruction word
- in_pc  in  WIDTH  PC of instruction
- in_rs1  in  WIDTH  rs1 value
- in_rs2  in  WIDTH  rs2 value
- alu_a  out  WIDTH  ALU operand a
- alu_b  out  WIDTH  ALU operand b
- alu_op  out  alu_op_t  ALU opcode
- alu_y  in  WIDTH  ALU result
- alu_bsr  in  3  {eq, lt signed, lt unsigned}
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_rd  out  5  destination register
- res_wb_en  out  1  write res_data to res_rd
- res_data  out  WIDTH  writeback value
- res_redirect  out  1  PC must change to res_target
- res_target  out  WIDTH  redirect target
- res_illegal  out  1  unsupported/illegal encoding
- res_misaligned  out  1  redirect target bits[1:0] != 0

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. During reset: state=IDLE, in_ready=0, all res_* outputs=0. Reset mid-operation aborts; no res_valid is produced for the aborted instruction.
- FSM states: IDLE, EXEC, TGT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch instr/pc/rs1/rs2 and go to EXEC. alu_op=ALU_ADD, a=b=0.
- EXEC: ALU inputs decoded combinationally from the latched instruction; alu_y/alu_bsr sampled at end of cycle.
  - OP (0110011): a=rs1, b=rs2, op from funct3; funct7[5] selects SUB (funct3=000) or SRA (101).
  - OP-IMM (0010011): a=rs1, b=sext I-imm; funct7[5] only meaningful for SRAI; never SUB.
  - LUI: op=PASS_RS2, b=U-imm.
  - AUIPC: ADD, a=pc, b=U-imm.
  - JAL/JALR: ADD, a=pc, b=4 → res_data; next state TGT.
  - BRANCH: a=rs1, b=rs2, op=SUB.
    - Taken per funct3: BEQ bsr[2], BNE !bsr[2], BLT bsr[1], BGE !bsr[1], BLTU bsr[0], BGEU !bsr[0]; funct3 010/011 are illegal.
    - Taken → TGT; not taken → DONE with redirect=0.
  - Any other opcode, or illegal funct: res_illegal=1, wb_en=0, redirect=0 → DONE.
- TGT: ADD; a=pc (JAL, BRANCH) or rs1 (JALR); b=sext J/B/I-imm.
  - res_target=alu_y with bit0 cleared for JALR.
  - res_redirect=1, unless target[1:0]!=0: then res_misaligned=1, redirect=0, wb_en=0.
  - Next state DONE.
- DONE: res_valid=1. All res_* held stable until res_ready, then IDLE. res_ready while not valid is ignored.
- Register rules: res_wb_en = writes-rd && rd!=0 && !illegal && !misaligned. Branches never write.
- Latency (accept at edge T, res_valid=1 from cycle T+N, zero backpressure):
  - ALU/LUI/AUIPC/not-taken branch/illegal: N=2.
  - JAL/JALR/taken branch: N=3.
- Throughput: one instruction in flight; no bypass from DONE to accept; in_ready=0 except in IDLE.
- Arithmetic: all immediates sign-extended to WIDTH; wrap-around modulo 2^WIDTH (pc+imm overflow wraps silently).

Decomposition:
- Shared package (datatypes.sv): alu_op_t (existing), opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH), funct3 branch constants, exec_state_t enum.
- Sub-module imm_gen: combinational I/B/J/U immediate extraction and sign-extension, reusable by decode.
- Integration: the ALU itself is instantiated by the parent, not inside exec_ctrl.

Test Plan:
- ADD x3: rs1=0x7FFFFFFF, rs2=1 → res_valid at T+2; alu_op=ALU_ADD; res_data=0x80000000, rd=3, wb_en=1, redirect=0.
- BLT: rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 → taken; res_target=0xF8, redirect=1, at T+3. Same operands with BLTU → not taken, res_valid at T+2.
- JALR rd=1: rs1=0x2003, imm=0, pc=0x40 → res_data=0x44; target 0x2002 has bit1 set → res_misaligned=1, redirect=0, wb_en=0.
- ADDI rd=0 → wb_en=0. funct3=010 branch → res_illegal=1. Hold res_ready=0 for 5 cycles → res_* stable, in_ready=0 throughout.
- Assert rst while in TGT → next cycle IDLE, res_valid never rises; following LUI 0x12345 → res_data=0x12345000.
- in_valid held high back-to-back with res_ready=1 → accepts spaced exactly latency+1 cycles apart; no instruction dropped or duplicated.
